bist_controller: RTL

BIST_CONTROLLER -- requirements
Module: bist_controller

---
 rtl/bist_pkg.sv | 27 ++
 rtl/bist_if.sv | 34 +++
 rtl/misr_16bit.sv | 31 +++
 rtl/bist_controller.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// ----------------------------------------------------------------------------
// bist_pkg
// Shared definitions for the BIST controller slice: the controller state
// encoding, the MISR feedback polynomial and a single-step MISR helper.
// No ports (package).
// ----------------------------------------------------------------------------
package bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_COMPARE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // x^16 + x^12 + x^3 + x + 1 (the x^16 term is implied by the shift-out)
  localparam logic [15:0] MISR_POLY = 16'h100B;

  // One MISR step: shift left, fold the outgoing MSB back through the
  // polynomial, then mix in the new data word.
  function automatic logic [15:0] misr_step(input logic [15:0] cur,
                                            input logic [15:0] data);
    return {cur[14:0], 1'b0} ^ (cur[15] ? MISR_POLY : 16'h0000) ^ data;
  endfunction

endpackage

// File: rtl/bist_if.sv
// ----------------------------------------------------------------------------
// bist_if
// Groups the controller's run-control and result/signature signals.
//   start, abort      run request / run termination
//   result[15:0]      multiplier output under test
//   golden_sig[15:0]  expected signature
//   pattern_en        advance enable for the upstream pattern source
//   misr_out[15:0]    current signature register
//   busy, done, pass  run status
// Modports: slave = controller side, master = driver/test side.
// ----------------------------------------------------------------------------
interface bist_if;

  logic        start;
  logic        abort;
  logic [15:0] result;
  logic [15:0] golden_sig;
  logic        pattern_en;
  logic [15:0] misr_out;
  logic        busy;
  logic        done;
  logic        pass;

  modport slave (
    input  start, abort, result, golden_sig,
    output pattern_en, misr_out, busy, done, pass
  );

  modport master (
    output start, abort, result, golden_sig,
    input  pattern_en, misr_out, busy, done, pass
  );

endinterface

// File: rtl/misr_16bit.sv
// ----------------------------------------------------------------------------
// misr_16bit
// 16-bit multiple-input signature register using the bist_pkg polynomial.
//   clk         clock, rising edge
//   rst         synchronous active-high reset, clears the signature
//   clear       synchronous clear at the start of a run
//   en          compress data into the signature this cycle
//   data[15:0]  word to compress
//   misr[15:0]  current signature
// ----------------------------------------------------------------------------
module misr_16bit
  import bist_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        en,
  input  logic [15:0] data,
  output logic [15:0] misr
);

  // clear wins over en so a new run always begins from an all-zero signature
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      misr <= 16'h0000;
    end else if (en) begin
      misr <= misr_step(misr, data);
    end
  end

endmodule

// File: rtl/bist_controller.sv
// ----------------------------------------------------------------------------
// bist_controller
// Runs a fixed-length BIST pass: enables the pattern source for
// PATTERN_COUNT cycles, compresses the delayed results into a MISR, waits
// PIPE_LATENCY cycles for the pipeline to drain, then compares the
// signature against golden_sig.
//   Parameters: PATTERN_COUNT (1..65535), PIPE_LATENCY (1..15)
//   clk   clock, rising edge
//   rst   synchronous active-high reset
//   bus   bist_if.slave: start/abort/result/golden_sig in,
//         pattern_en/misr_out/busy/done/pass out
// ----------------------------------------------------------------------------
module bist_controller
  import bist_pkg::*;
#(
  parameter int PATTERN_COUNT = 255,
  parameter int PIPE_LATENCY  = 3
) (
  input  logic   clk,
  input  logic   rst,
  bist_if.slave  bus
);

  state_t                  state;
  state_t                  state_nxt;
  logic [15:0]             pat_cnt;
  logic [3:0]              drain_cnt;
  logic [PIPE_LATENCY-1:0] cap_pipe;
  logic                    cap_en;
  logic                    start_ok;
  logic                    misr_en;
  logic                    pass_q;
  logic                    pattern_en;

  // start is honoured only when idle or finished; abort overrides start
  assign start_ok = bus.start && !bus.abort &&
                    ((state == ST_IDLE) || (state == ST_DONE));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (bus.abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (bus.start) state_nxt = ST_RUN;
        ST_RUN:     if (pat_cnt <= 16'd1) state_nxt = ST_DRAIN;
        ST_DRAIN:   if (drain_cnt <= 4'd1) state_nxt = ST_COMPARE;
        ST_COMPARE: state_nxt = ST_DONE;
        ST_DONE:    if (bus.start) state_nxt = ST_RUN;
        default:    state_nxt = ST_IDLE;
      endcase
    end
  end

  // Output decode
  always_comb begin
    pattern_en = 1'b0;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    case (state)
      ST_RUN: begin
        pattern_en = 1'b1;
        bus.busy   = 1'b1;
      end
      ST_DRAIN:   bus.busy = 1'b1;
      ST_COMPARE: bus.busy = 1'b1;
      ST_DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  assign bus.pattern_en = pattern_en;
  assign bus.pass       = pass_q;

  // Pattern and drain counters; both count down and stop at zero.
  // The drain counter is loaded on the RUN->DRAIN transition.
  always_ff @(posedge clk) begin
    if (rst || bus.abort) begin
      pat_cnt   <= 16'd0;
      drain_cnt <= 4'd0;
    end else if (start_ok) begin
      pat_cnt   <= 16'(PATTERN_COUNT);
      drain_cnt <= 4'd0;
    end else begin
      if (state == ST_RUN && pat_cnt != 16'd0) begin
        pat_cnt <= pat_cnt - 16'd1;
      end
      if (state == ST_RUN && state_nxt == ST_DRAIN) begin
        drain_cnt <= 4'(PIPE_LATENCY);
      end else if (state == ST_DRAIN && drain_cnt != 4'd0) begin
        drain_cnt <= drain_cnt - 4'd1;
      end
    end
  end

  // Capture enable is pattern_en delayed by PIPE_LATENCY cycles so each
  // result is compressed exactly when it arrives from the pipeline.
  generate
    if (PIPE_LATENCY == 1) begin : g_pipe_one
      always_ff @(posedge clk) begin
        if (rst || bus.abort) begin
          cap_pipe <= '0;
        end else begin
          cap_pipe <= pattern_en;
        end
      end
    end else begin : g_pipe_many
      always_ff @(posedge clk) begin
        if (rst || bus.abort) begin
          cap_pipe <= '0;
        end else begin
          cap_pipe <= {cap_pipe[PIPE_LATENCY-2:0], pattern_en};
        end
      end
    end
  endgenerate

  assign cap_en = cap_pipe[PIPE_LATENCY-1];

  // An abort freezes the signature at its current value
  assign misr_en = cap_en && !bus.abort;

  // Pass flag: cleared on a new run or abort, loaded once in COMPARE
  always_ff @(posedge clk) begin
    if (rst || bus.abort || start_ok) begin
      pass_q <= 1'b0;
    end else if (state == ST_COMPARE) begin
      pass_q <= (bus.misr_out == bus.golden_sig);
    end
  end

  misr_16bit u_misr (
    .clk   (clk),
    .rst   (rst),
    .clear (start_ok),
    .en    (misr_en),
    .data  (bus.result),
    .misr  (bus.misr_out)
  );

endmodule
